alu_sel_input: RTL

Front-panel input block for the 4-bit ALU board. It reads three raw pushbuttons, synchronizes and debounces each, and turns debounced presses into the 3-bit operation select `SEL` and the `CAMBIO` mode flag. These are the same signals the RGB status LED driver displays, so this block is the input end of that select/status path. Each qualified press changes the outputs exactly once, however long the button is held and however much its contacts bounce.

---
 rtl/alu_sel_input.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_sel_input.sv
// Front-panel input block: synchronizes and debounces three pushbuttons and
// turns qualified presses into the ALU operation select and mode flag.
module alu_sel_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SEL_MAX         = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_MODE,
  output logic [2:0] SEL,
  output logic       CAMBIO,
  output logic       SEL_CHG
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    SEL_TOP  = 3'(SEL_MAX);

  typedef enum logic [1:0] {
    IDX_UP   = 2'd0,
    IDX_DN   = 2'd1,
    IDX_MODE = 2'd2
  } btn_idx_e;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    deb_dly_q, deb_dly_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    press;
  logic [2:0]    sel_q, sel_d;
  logic          cambio_q, cambio_d;
  logic          sel_chg_q, sel_chg_d;

  assign btn_raw = {BTN_MODE, BTN_DOWN, BTN_UP};

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    press = deb_q & ~deb_dly_q;

    sel_d     = sel_q;
    sel_chg_d = 1'b0;
    case ({press[IDX_UP], press[IDX_DN]})
      2'b10: begin
        sel_d     = (sel_q == SEL_TOP) ? '0 : sel_q + 3'd1;
        sel_chg_d = 1'b1;
      end
      2'b01: begin
        sel_d     = (sel_q == '0) ? SEL_TOP : sel_q - 3'd1;
        sel_chg_d = 1'b1;
      end
      default: begin
        sel_d     = sel_q;
        sel_chg_d = 1'b0;
      end
    endcase

    cambio_d = cambio_q ^ press[IDX_MODE];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      sel_q     <= '0;
      cambio_q  <= 1'b0;
      sel_chg_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sel_q     <= sel_d;
      cambio_q  <= cambio_d;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign SEL     = sel_q;
  assign CAMBIO  = cambio_q;
  assign SEL_CHG = sel_chg_q;

endmodule
